pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 64, width of each value channel.
REQ-002 Parameter NUM_VAL, default 2, number of value channels (range 1..4).
REQ-003 Parameter REG_W, default 4, register-ID width.
REQ-004 Parameter CNT_W, default 16, width of the event counters.
REQ-005 Parameter EXC_FREEZE, default 1: 1 = freeze on exception, 0 = no freeze.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset, synchronous and active-high.
REQ-008 stall  input  1  hold current contents.
REQ-009 bubble  input  1  load a NOP bubble.
REQ-010 in_stat  input  4  upstream status code.
REQ-011 in_icode  input  4  upstream instruction code.
REQ-012 in_cnd  input  1  upstream condition flag.
REQ-013 in_val  input  NUM_VAL*DATA_W  value channels; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-014 in_dstE, in_dstM  input  REG_W each  destination register IDs.
REQ-015 out_stat, out_icode, out_cnd, out_val, out_dstE, out_dstM  output  widths as inputs  registered copies.
REQ-016 out_valid  output  1  1 when the stage holds a real (non-bubble) instruction.
REQ-017 exc_latched  output  1  1 while frozen on an exception.
REQ-018 stall_cnt, bubble_cnt  output  CNT_W each  saturating event counters.
REQ-019 conflict  output  1  sticky; set when stall and bubble are asserted in the same cycle.

Function
REQ-020 Constants: AOK = 4'h1, NOP icode = 4'h1, RNONE = all ones (REG_W bits).
REQ-021 Per-edge priority: rst, then freeze, then bubble, then stall, then load.
REQ-022 Load (no rst, stall or bubble, not frozen): every out_* takes its in_* value one cycle later; out_valid = 1.
REQ-023 Bubble: out_stat = AOK, out_icode = NOP, out_cnd = 0, out_val = 0, out_dstE = out_dstM = RNONE, out_valid = 0.
REQ-024 Stall: all out_* and out_valid hold their values.
REQ-025 Stall and bubble asserted together: bubble action wins, conflict set to 1 and held until rst.
REQ-026 stall_cnt increments by 1 on each edge where stall = 1 and bubble = 0, not frozen and not rst; holds at all ones.
REQ-027 bubble_cnt increments by 1 on each edge where bubble = 1, not frozen and not rst; holds at all ones.
REQ-028 Freeze, EXC_FREEZE = 1: when an edge loads in_stat != AOK, exc_latched goes to 1 on that same edge.
REQ-029 While exc_latched = 1, all outputs and counters hold regardless of stall and bubble; only rst clears the freeze.
REQ-030 EXC_FREEZE = 0: exc_latched is tied to 0; non-AOK status passes through like any other value.
REQ-031 Latency is exactly 1 cycle from input to output; there is no combinational path from input to output.
REQ-032 Channels are independent; NUM_VAL = 1 and NUM_VAL = 4 behave identically per channel.

Reset
REQ-033 On a rst edge: out_stat = AOK, out_icode = NOP, out_cnd = 0, out_val = 0, out_dstE = out_dstM = RNONE.
REQ-034 On a rst edge: out_valid = 0, exc_latched = 0, conflict = 0, stall_cnt = 0, bubble_cnt = 0.
REQ-035 rst asserted during a stall, bubble or freeze overrides it; the next edge with rst = 0 follows normal priority.

Verification
REQ-036 Load: in_icode = 4'h6, in_val[0] = 64'h10, in_dstE = 4'h3, no stall or bubble -> next cycle out_icode = 6, out_val[0] = 0x10, out_dstE = 3, out_valid = 1.
REQ-037 Stall: stall = 1 for 3 cycles while inputs change -> outputs unchanged, stall_cnt = 3.
REQ-038 Bubble and conflict: stall = bubble = 1 for one cycle -> out_icode = 1, out_dstE = 4'hF, out_valid = 0, conflict = 1, bubble_cnt = 1, stall_cnt = 0.
REQ-039 Freeze: load in_stat = 4'h3, then apply 5 cycles of loads and bubbles -> out_stat stays 3, exc_latched = 1, counters unchanged; rst -> reset values.
REQ-040 Saturation: CNT_W = 2, stall = 1 for 6 cycles -> stall_cnt sequence 1, 2, 3, 3, 3, 3.
REQ-041 Parameter sweep: NUM_VAL = 3, DATA_W = 32, distinct per-channel patterns -> each channel round-trips unchanged, no cross-channel corruption.

Source files
------------

// File: rtl/pipe_stage_reg_if.sv
// Bundle of the pipeline-register stage: upstream controls/values in, registered copies and
// event/status observability out. clk and rst stay plain ports on the stage itself.
interface pipe_stage_reg_if #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned NUM_VAL = 2,
  parameter int unsigned REG_W   = 4,
  parameter int unsigned CNT_W   = 16
);

  logic                        stall;
  logic                        bubble;
  logic [3:0]                  in_stat;
  logic [3:0]                  in_icode;
  logic                        in_cnd;
  logic [NUM_VAL*DATA_W-1:0]   in_val;
  logic [REG_W-1:0]            in_dstE;
  logic [REG_W-1:0]            in_dstM;

  logic [3:0]                  out_stat;
  logic [3:0]                  out_icode;
  logic                        out_cnd;
  logic [NUM_VAL*DATA_W-1:0]   out_val;
  logic [REG_W-1:0]            out_dstE;
  logic [REG_W-1:0]            out_dstM;
  logic                        out_valid;
  logic                        exc_latched;
  logic [CNT_W-1:0]            stall_cnt;
  logic [CNT_W-1:0]            bubble_cnt;
  logic                        conflict;

  modport master (
    output stall, bubble, in_stat, in_icode, in_cnd, in_val, in_dstE, in_dstM,
    input  out_stat, out_icode, out_cnd, out_val, out_dstE, out_dstM, out_valid,
    input  exc_latched, stall_cnt, bubble_cnt, conflict
  );

  modport slave (
    input  stall, bubble, in_stat, in_icode, in_cnd, in_val, in_dstE, in_dstM,
    output out_stat, out_icode, out_cnd, out_val, out_dstE, out_dstM, out_valid,
    output exc_latched, stall_cnt, bubble_cnt, conflict
  );

endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with stall/bubble control, optional freeze on a non-AOK status,
// saturating stall/bubble event counters and a sticky stall+bubble conflict flag.
module pipe_stage_reg #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned NUM_VAL    = 2,
  parameter int unsigned REG_W      = 4,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned EXC_FREEZE = 1
) (
  input logic             clk,
  input logic             rst,
  pipe_stage_reg_if.slave io_bus
);

  localparam logic [3:0]       STAT_AOK  = 4'h1;
  localparam logic [3:0]       ICODE_NOP = 4'h1;
  localparam logic [REG_W-1:0] RNONE     = '1;
  localparam bit               FreezeEn  = (EXC_FREEZE != 0);

  logic [3:0]       r_stat;
  logic [3:0]       r_icode;
  logic             r_cnd;
  logic [REG_W-1:0] r_dste;
  logic [REG_W-1:0] r_dstm;
  logic             r_valid;
  logic             r_exc;
  logic             r_conflict;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  logic w_frozen;
  logic w_bubble_evt;
  logic w_stall_evt;
  logic w_load;
  logic w_exc_evt;

  // Freeze outranks bubble and stall; a stall only counts when no bubble overrides it.
  assign w_frozen     = FreezeEn & r_exc;
  assign w_bubble_evt = io_bus.bubble & ~w_frozen;
  assign w_stall_evt  = io_bus.stall & ~io_bus.bubble & ~w_frozen;
  assign w_load       = ~io_bus.stall & ~io_bus.bubble & ~w_frozen;
  assign w_exc_evt    = FreezeEn & w_load & (io_bus.in_stat != STAT_AOK);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat       <= STAT_AOK;
      r_icode      <= ICODE_NOP;
      r_cnd        <= 1'b0;
      r_dste       <= RNONE;
      r_dstm       <= RNONE;
      r_valid      <= 1'b0;
      r_exc        <= 1'b0;
      r_conflict   <= 1'b0;
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_bubble_evt) begin
        r_stat  <= STAT_AOK;
        r_icode <= ICODE_NOP;
        r_cnd   <= 1'b0;
        r_dste  <= RNONE;
        r_dstm  <= RNONE;
        r_valid <= 1'b0;
        if (!(&r_bubble_cnt)) r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        if (io_bus.stall)     r_conflict   <= 1'b1;
      end else if (w_stall_evt) begin
        if (!(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end else if (w_load) begin
        r_stat  <= io_bus.in_stat;
        r_icode <= io_bus.in_icode;
        r_cnd   <= io_bus.in_cnd;
        r_dste  <= io_bus.in_dstE;
        r_dstm  <= io_bus.in_dstM;
        r_valid <= 1'b1;
      end
      if (w_exc_evt) r_exc <= 1'b1;
    end
  end

  // Value channels are held in independent per-channel registers sharing the same controls.
  for (genvar k = 0; k < NUM_VAL; k++) begin : g_chan
    logic [DATA_W-1:0] r_val;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_val <= '0;
      end else if (w_bubble_evt) begin
        r_val <= '0;
      end else if (w_load) begin
        r_val <= io_bus.in_val[k*DATA_W +: DATA_W];
      end
    end

    assign io_bus.out_val[k*DATA_W +: DATA_W] = r_val;
  end

  assign io_bus.out_stat    = r_stat;
  assign io_bus.out_icode   = r_icode;
  assign io_bus.out_cnd     = r_cnd;
  assign io_bus.out_dstE    = r_dste;
  assign io_bus.out_dstM    = r_dstm;
  assign io_bus.out_valid   = r_valid;
  assign io_bus.exc_latched = w_frozen;
  assign io_bus.conflict    = r_conflict;
  assign io_bus.stall_cnt   = r_stall_cnt;
  assign io_bus.bubble_cnt  = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table and randomized model comparison on the
// default configuration, plus a narrow-counter / three-channel / no-freeze instance.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(64), .NUM_VAL(2), .REG_W(4), .CNT_W(16)) ifa ();
  pipe_stage_reg_if #(.DATA_W(32), .NUM_VAL(3), .REG_W(4), .CNT_W(2))  ifb ();

  pipe_stage_reg #(
    .DATA_W(64), .NUM_VAL(2), .REG_W(4), .CNT_W(16), .EXC_FREEZE(1)
  ) u_dut_a (
    .clk    (clk),
    .rst    (rst_a),
    .io_bus (ifa.slave)
  );

  pipe_stage_reg #(
    .DATA_W(32), .NUM_VAL(3), .REG_W(4), .CNT_W(2), .EXC_FREEZE(0)
  ) u_dut_b (
    .clk    (clk),
    .rst    (rst_b),
    .io_bus (ifb.slave)
  );

  typedef struct {
    logic         rst, stall, bubble;
    logic [3:0]   stat, icode;
    logic         cnd;
    logic [127:0] val;
    logic [3:0]   dste, dstm;
    logic [3:0]   e_stat, e_icode;
    logic         e_cnd;
    logic [127:0] e_val;
    logic [3:0]   e_dste, e_dstm;
    logic         e_valid, e_exc, e_conf;
    logic [15:0]  e_scnt, e_bcnt;
  } vec_t;

  // Reference model state for DUT A.
  logic [3:0]   m_stat, m_icode, m_dste, m_dstm;
  logic         m_cnd, m_valid, m_exc, m_conf;
  logic [127:0] m_val;
  logic [15:0]  m_scnt, m_bcnt;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic r, s, b, input logic [3:0] st, ic, input logic cd, input logic [127:0] v,
    input logic [3:0] de, dm, input logic [3:0] es, ei, input logic ec,
    input logic [127:0] ev, input logic [3:0] ede, edm, input logic evd, eex, ecf,
    input logic [15:0] esc, ebc);
    vec_t t;
    t.rst = r;  t.stall = s;  t.bubble = b;  t.stat = st;  t.icode = ic;  t.cnd = cd;
    t.val = v;  t.dste = de;  t.dstm = dm;
    t.e_stat = es;  t.e_icode = ei;  t.e_cnd = ec;  t.e_val = ev;  t.e_dste = ede;
    t.e_dstm = edm; t.e_valid = evd; t.e_exc = eex; t.e_conf = ecf;
    t.e_scnt = esc; t.e_bcnt = ebc;
    return t;
  endfunction

  task automatic drive_a(input logic r, s, b, input logic [3:0] st, ic, input logic cd,
                         input logic [127:0] v, input logic [3:0] de, dm);
    rst_a         = r;
    ifa.stall     = s;
    ifa.bubble    = b;
    ifa.in_stat   = st;
    ifa.in_icode  = ic;
    ifa.in_cnd    = cd;
    ifa.in_val    = v;
    ifa.in_dstE   = de;
    ifa.in_dstM   = dm;
  endtask

  // One clock edge as seen by the rules: reset, else frozen, else bubble, stall or load.
  task automatic model_edge(input logic r, s, b, input logic [3:0] st, ic, input logic cd,
                            input logic [127:0] v, input logic [3:0] de, dm);
    if (r) begin
      m_stat = 4'h1; m_icode = 4'h1; m_cnd = 1'b0; m_val = '0; m_dste = 4'hF; m_dstm = 4'hF;
      m_valid = 1'b0; m_exc = 1'b0; m_conf = 1'b0; m_scnt = '0; m_bcnt = '0;
    end else if (!m_exc) begin
      if (b) begin
        m_stat = 4'h1; m_icode = 4'h1; m_cnd = 1'b0; m_val = '0;
        m_dste = 4'hF; m_dstm = 4'hF; m_valid = 1'b0;
        m_bcnt = (m_bcnt == 16'hFFFF) ? m_bcnt : m_bcnt + 16'd1;
        m_conf = m_conf | s;
      end else if (s) begin
        m_scnt = (m_scnt == 16'hFFFF) ? m_scnt : m_scnt + 16'd1;
      end else begin
        m_stat = st; m_icode = ic; m_cnd = cd; m_val = v; m_dste = de; m_dstm = dm;
        m_valid = 1'b1;
        m_exc = (st != 4'h1);
      end
    end
  endtask

  task automatic drive_b(input logic s, b, input logic [3:0] st, input logic [95:0] v);
    ifb.stall    = s;
    ifb.bubble   = b;
    ifb.in_stat  = st;
    ifb.in_icode = 4'h2;
    ifb.in_cnd   = 1'b0;
    ifb.in_val   = v;
    ifb.in_dstE  = 4'h1;
    ifb.in_dstM  = 4'h2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    logic [127:0] v1, v2, v3, v4, v5, v6, vr;
    logic [31:0]  pat [3];
    logic [95:0]  vb;
    logic         r, s, b;
    logic [3:0]   st, ic, de, dm;
    logic         cd;
    logic [1:0]   sat_exp [6];

    drive_a(1'b1, 1'b0, 1'b0, 4'h1, 4'h0, 1'b0, '0, 4'h0, 4'h0);
    drive_b(1'b0, 1'b0, 4'h1, '0);

    v1 = {64'h20, 64'h10};
    v2 = {64'hDEAD, 64'hBEEF};
    v3 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210};
    v4 = {64'h5555, 64'hAAAA};
    v5 = {64'h3333_0000_0000_3333, 64'hC0DE};
    v6 = {64'h7, 64'h8};

    // rst/stall/bubble, stat, icode, cnd, val, dstE, dstM -> expected outputs and state
    tbl.push_back(mk(1,0,0, 4'h1,4'h0,0,'0,4'h0,4'h0, 4'h1,4'h1,0,'0,4'hF,4'hF, 0,0,0, 0,0));
    tbl.push_back(mk(0,0,0, 4'h1,4'h6,1,v1,4'h3,4'h5, 4'h1,4'h6,1,v1,4'h3,4'h5, 1,0,0, 0,0));
    tbl.push_back(mk(0,1,0, 4'h2,4'h7,0,v2,4'h4,4'h6, 4'h1,4'h6,1,v1,4'h3,4'h5, 1,0,0, 1,0));
    tbl.push_back(mk(0,1,0, 4'h1,4'h8,0,v3,4'h9,4'h6, 4'h1,4'h6,1,v1,4'h3,4'h5, 1,0,0, 2,0));
    tbl.push_back(mk(0,1,0, 4'h4,4'h9,1,v4,4'hA,4'hB, 4'h1,4'h6,1,v1,4'h3,4'h5, 1,0,0, 3,0));
    tbl.push_back(mk(1,1,1, 4'h1,4'h9,1,v4,4'hA,4'hB, 4'h1,4'h1,0,'0,4'hF,4'hF, 0,0,0, 0,0));
    tbl.push_back(mk(0,0,0, 4'h1,4'h2,0,v3,4'h4,4'h8, 4'h1,4'h2,0,v3,4'h4,4'h8, 1,0,0, 0,0));
    tbl.push_back(mk(0,1,1, 4'h1,4'h5,1,v4,4'h9,4'h9, 4'h1,4'h1,0,'0,4'hF,4'hF, 0,0,1, 0,1));
    tbl.push_back(mk(0,0,0, 4'h3,4'h3,1,v5,4'h7,4'h2, 4'h3,4'h3,1,v5,4'h7,4'h2, 1,1,1, 0,1));
    tbl.push_back(mk(0,0,0, 4'h1,4'hA,0,v1,4'h1,4'h1, 4'h3,4'h3,1,v5,4'h7,4'h2, 1,1,1, 0,1));
    tbl.push_back(mk(0,0,1, 4'h1,4'hB,0,v2,4'h2,4'h2, 4'h3,4'h3,1,v5,4'h7,4'h2, 1,1,1, 0,1));
    tbl.push_back(mk(0,1,0, 4'h1,4'hC,1,v3,4'h3,4'h3, 4'h3,4'h3,1,v5,4'h7,4'h2, 1,1,1, 0,1));
    tbl.push_back(mk(0,1,1, 4'h1,4'hD,1,v4,4'h4,4'h4, 4'h3,4'h3,1,v5,4'h7,4'h2, 1,1,1, 0,1));
    tbl.push_back(mk(0,0,1, 4'h1,4'hE,0,v6,4'h5,4'h5, 4'h3,4'h3,1,v5,4'h7,4'h2, 1,1,1, 0,1));
    tbl.push_back(mk(1,0,0, 4'h1,4'h4,0,v6,4'h1,4'h2, 4'h1,4'h1,0,'0,4'hF,4'hF, 0,0,0, 0,0));
    tbl.push_back(mk(0,0,0, 4'h1,4'h4,0,v6,4'h1,4'h2, 4'h1,4'h4,0,v6,4'h1,4'h2, 1,0,0, 0,0));
    tbl.push_back(mk(0,0,1, 4'h1,4'h4,0,v6,4'h1,4'h2, 4'h1,4'h1,0,'0,4'hF,4'hF, 0,0,0, 0,1));

    foreach (tbl[i]) begin
      drive_a(tbl[i].rst, tbl[i].stall, tbl[i].bubble, tbl[i].stat, tbl[i].icode, tbl[i].cnd,
              tbl[i].val, tbl[i].dste, tbl[i].dstm);
      tick();
      check($sformatf("row%0d.stat", i),  128'(ifa.out_stat),    128'(tbl[i].e_stat));
      check($sformatf("row%0d.icode", i), 128'(ifa.out_icode),   128'(tbl[i].e_icode));
      check($sformatf("row%0d.cnd", i),   128'(ifa.out_cnd),     128'(tbl[i].e_cnd));
      check($sformatf("row%0d.val", i),   128'(ifa.out_val),     tbl[i].e_val);
      check($sformatf("row%0d.dstE", i),  128'(ifa.out_dstE),    128'(tbl[i].e_dste));
      check($sformatf("row%0d.dstM", i),  128'(ifa.out_dstM),    128'(tbl[i].e_dstm));
      check($sformatf("row%0d.valid", i), 128'(ifa.out_valid),   128'(tbl[i].e_valid));
      check($sformatf("row%0d.exc", i),   128'(ifa.exc_latched), 128'(tbl[i].e_exc));
      check($sformatf("row%0d.conf", i),  128'(ifa.conflict),    128'(tbl[i].e_conf));
      check($sformatf("row%0d.scnt", i),  128'(ifa.stall_cnt),   128'(tbl[i].e_scnt));
      check($sformatf("row%0d.bcnt", i),  128'(ifa.bubble_cnt),  128'(tbl[i].e_bcnt));
    end

    // Randomized traffic on DUT A against the reference model.
    model_edge(1'b1, 1'b0, 1'b0, 4'h1, 4'h0, 1'b0, '0, 4'h0, 4'h0);
    drive_a(1'b1, 1'b0, 1'b0, 4'h1, 4'h0, 1'b0, '0, 4'h0, 4'h0);
    tick();
    for (int n = 0; n < 600; n++) begin
      r  = ($urandom_range(0, 39) == 0);
      s  = ($urandom_range(0, 3) == 0);
      b  = ($urandom_range(0, 4) == 0);
      st = ($urandom_range(0, 24) == 0) ? 4'($urandom_range(2, 15)) : 4'h1;
      ic = 4'($urandom);
      cd = 1'($urandom);
      vr = {$urandom, $urandom, $urandom, $urandom};
      de = 4'($urandom);
      dm = 4'($urandom);
      drive_a(r, s, b, st, ic, cd, vr, de, dm);
      model_edge(r, s, b, st, ic, cd, vr, de, dm);
      tick();
      check($sformatf("rand%0d.stat", n),  128'(ifa.out_stat),    128'(m_stat));
      check($sformatf("rand%0d.icode", n), 128'(ifa.out_icode),   128'(m_icode));
      check($sformatf("rand%0d.cnd", n),   128'(ifa.out_cnd),     128'(m_cnd));
      check($sformatf("rand%0d.val", n),   128'(ifa.out_val),     m_val);
      check($sformatf("rand%0d.dstE", n),  128'(ifa.out_dstE),    128'(m_dste));
      check($sformatf("rand%0d.dstM", n),  128'(ifa.out_dstM),    128'(m_dstm));
      check($sformatf("rand%0d.valid", n), 128'(ifa.out_valid),   128'(m_valid));
      check($sformatf("rand%0d.exc", n),   128'(ifa.exc_latched), 128'(m_exc));
      check($sformatf("rand%0d.conf", n),  128'(ifa.conflict),    128'(m_conf));
      check($sformatf("rand%0d.scnt", n),  128'(ifa.stall_cnt),   128'(m_scnt));
      check($sformatf("rand%0d.bcnt", n),  128'(ifa.bubble_cnt),  128'(m_bcnt));
    end

    // DUT B: 2-bit counters saturate, three 32-bit channels, no freeze.
    rst_b = 1'b1;
    tick();
    check("b.rst.scnt",  128'(ifb.stall_cnt),   128'(0));
    check("b.rst.valid", 128'(ifb.out_valid),   128'(0));
    check("b.rst.val",   128'(ifb.out_val),     128'(0));
    rst_b = 1'b0;
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 6; i++) begin
      drive_b(1'b1, 1'b0, 4'h1, {3{32'($urandom)}});
      tick();
      check($sformatf("b.sat%0d.scnt", i), 128'(ifb.stall_cnt), 128'(sat_exp[i]));
      check($sformatf("b.sat%0d.val", i),  128'(ifb.out_val),   128'(0));
    end
    pat = '{32'hC0DE_0001, 32'h5A5A_A5A5, 32'hFFFF_0000};
    for (int k = 0; k < 3; k++) begin
      vb = '0;
      vb[k*32 +: 32] = pat[k];
      drive_b(1'b0, 1'b0, 4'h2, vb);
      tick();
      for (int j = 0; j < 3; j++) begin
        check($sformatf("b.walk%0d.ch%0d", k, j), 128'(ifb.out_val[j*32 +: 32]),
              128'((j == k) ? pat[j] : 32'h0));
      end
      check($sformatf("b.walk%0d.stat", k), 128'(ifb.out_stat),    128'(4'h2));
      check($sformatf("b.walk%0d.exc", k),  128'(ifb.exc_latched), 128'(0));
    end
    drive_b(1'b0, 1'b0, 4'h5, {pat[2], pat[1], pat[0]});
    tick();
    for (int j = 0; j < 3; j++)
      check($sformatf("b.all.ch%0d", j), 128'(ifb.out_val[j*32 +: 32]), 128'(pat[j]));
    drive_b(1'b0, 1'b0, 4'h1, {32'h3, 32'h2, 32'h1});
    tick();
    check("b.nofreeze.stat", 128'(ifb.out_stat), 128'(4'h1));
    check("b.nofreeze.val",  128'(ifb.out_val),  128'({32'h3, 32'h2, 32'h1}));
    check("b.nofreeze.valid", 128'(ifb.out_valid), 128'(1));
    for (int i = 0; i < 4; i++) begin
      drive_b(1'b0, 1'b1, 4'h1, {3{32'h1234_5678}});
      tick();
      check($sformatf("b.bub%0d.bcnt", i), 128'(ifb.bubble_cnt),
            128'((i < 3) ? i + 1 : 3));
      check($sformatf("b.bub%0d.val", i),  128'(ifb.out_val),   128'(0));
      check($sformatf("b.bub%0d.valid", i), 128'(ifb.out_valid), 128'(0));
    end
    check("b.scnt.hold", 128'(ifb.stall_cnt), 128'(3));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
